// File: rtl/tv_sequencer.sv
// tv_sequencer: walks a basic component through every input vector and checks it against a golden model.
module tv_sequencer #(
    parameter int SETTLE = 1,
    parameter int STIM_W = 6,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [1:0]        dut_y,
    output logic [STIM_W-1:0] stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mode_err,
    output logic [CNT_W-1:0]  vec_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [STIM_W-1:0] fail_vec,
    output logic              fail_valid
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
    state_t state, state_n;
    logic [2:0] mode_q;
    logic [3:0] settle;
    logic [1:0] exp_y, msk;
    logic [STIM_W-1:0] last;
    logic mis, go, bad, fin;
    always_comb begin
        exp_y = 2'b00;
        msk = 2'b01;
        last = STIM_W'(3);
        case (mode_q)
            3'd0: exp_y = {1'b0, stim[0] & stim[1]};
            3'd1: begin
                exp_y = {stim[0] & stim[1], stim[0] ^ stim[1]};
                msk = 2'b11;
            end
            3'd2: begin
                exp_y = {(stim[0] & stim[1]) | (stim[2] & (stim[0] | stim[1])), ^stim[2:0]};
                msk = 2'b11;
                last = STIM_W'(7);
            end
            3'd3: begin
                exp_y = {1'b0, stim[2] ? stim[1] : stim[0]};
                last = STIM_W'(7);
            end
            3'd4: begin
                exp_y = {1'b0, stim[stim[5:4]]};
                last = STIM_W'(63);
            end
            default: ;
        endcase
        // Case inequality so an X/Z on a compared bit is reported as a mismatch.
        mis = (((dut_y ^ exp_y) & msk) !== 2'b00);
        go = start && (state == IDLE || state == DONE);
        bad = mode > 3'd4;
        fin = stim == last;
        state_n = state;
        case (state)
            IDLE, DONE: if (go) state_n = bad ? DONE : DRIVE;
            DRIVE: if (settle == 4'(SETTLE)) state_n = CHECK;
            CHECK: state_n = fin ? DONE : DRIVE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // The first vector starts its settle count at 0, later ones at 1, so the
    // component gets one extra cycle after leaving the previous run's vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 3'd0;
            settle <= 4'd0;
            stim <= '0;
            pass <= 1'b0;
            mode_err <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            fail_vec <= '0;
            fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (go) begin
                    mode_q <= mode;
                    settle <= 4'd0;
                    stim <= '0;
                    pass <= 1'b0;
                    mode_err <= bad;
                    vec_count <= '0;
                    err_count <= '0;
                    fail_vec <= '0;
                    fail_valid <= 1'b0;
                end
                DRIVE: settle <= settle + 4'd1;
                CHECK: begin
                    vec_count <= vec_count + CNT_W'(1);
                    settle <= 4'd1;
                    if (mis) begin
                        err_count <= err_count + CNT_W'(1);
                        if (!fail_valid) begin
                            fail_vec <= stim;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (fin) pass <= !mis && err_count == '0;
                    else stim <= stim + STIM_W'(1);
                end
                default: ;
            endcase
        end
    end
    assign busy = state == DRIVE || state == CHECK;
    assign done = state == DONE;
endmodule

// File: doc/tv_sequencer.md
Name: tv_sequencer

Overview:
- Sequential exercise stage for the basic-component library: gate, half adder/subtractor, full adder/subtractor, 2x1 mux and 4x1 mux.
- Sits upstream of the selected component and drives its inputs with every input combination in order.
- Also sits downstream of it: after a settle window it samples the component outputs and compares them against an internal golden model.
- Reports a vector count, an error count, the first failing vector, and a final pass/fail.

Parameters:
- SETTLE, default 1: cycles the stimulus is held before outputs are sampled. Legal range 1..15.
- STIM_W, default 6: stimulus width. Fixed at 6, the widest component (4x1 mux: d0..d3 + sel[1:0]).
- CNT_W, default 7: width of the vector and error counters. Must be able to hold 64.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run. Sampled only in IDLE or DONE.
- mode  in  3  component select: 0 gate, 1 half adder/subtractor, 2 full adder/subtractor, 3 mux 2x1, 4 mux 4x1. Latched when start is accepted.
- dut_y  in  2  component outputs: [0]=y/y1, [1]=y2. Unused bits are ignored.
- stim  out  6  component inputs, registered.
- busy  out  1  high in DRIVE and CHECK.
- done  out  1  high in DONE; held until the next accepted start or rst.
- pass  out  1  valid while done: 1 only if err_count==0 and the mode was legal.
- mode_err  out  1  set when start is accepted with mode 5..7.
- vec_count  out  CNT_W  number of vectors checked in the current run.
- err_count  out  CNT_W  number of mismatching vectors.
- fail_vec  out  6  stim value of the first mismatch.
- fail_valid  out  1  fail_vec holds a valid value.

Behaviour:
- Reset: state IDLE. All outputs are 0: stim, busy, done, pass, mode_err, vec_count, err_count, fail_vec, fail_valid. rst mid-run aborts immediately, with no partial done.
- Stimulus bit map:
  - mode 0/1: stim[0]=i1, stim[1]=i2.
  - mode 2: adds stim[2]=i3.
  - mode 3: stim[0]=d0, stim[1]=d1, stim[2]=sel.
  - mode 4: stim[3:0]=d3..d0, stim[5:4]=sel.
  - Bits above the mode's input count stay 0.
- Vector count N: 4, 4, 8, 8, 64 for modes 0..4. stim counts upward from 0 to N-1, binary, no skips.
- Golden model (exp), compare mask (m):
  - mode 0: exp[0]=a&b, m=01.
  - mode 1: exp[0]=a^b, exp[1]=a&b, m=11.
  - mode 2: exp[0]=a^b^c, exp[1]=majority(a,b,c), m=11.
  - mode 3: exp[0]=sel?d1:d0, m=01.
  - mode 4: exp[0]=d[sel], m=01.
  - Mismatch is ((dut_y^exp)&m)!=0. X/Z on a masked bit counts as a mismatch.
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE/DONE + start with legal mode:
    - latch mode;
    - clear vec_count, err_count, fail_valid, fail_vec, done, pass, mode_err;
    - stim=0;
    - go to DRIVE.
  - IDLE/DONE + start with mode 5..7: mode_err=1, pass=0, counters cleared, go to DONE.
  - DRIVE: hold stim for exactly SETTLE cycles (internal 4-bit settle counter), then go to CHECK.
  - CHECK, one cycle, stim still held:
    - vec_count+1;
    - on mismatch, err_count+1;
    - on the first mismatch only, fail_vec=stim and fail_valid=1.
    - If stim==N-1: go to DONE, done=1, pass=(err_count_next==0).
    - Otherwise: stim+1, go to DRIVE.
  - DONE: stim holds the last vector and all results are held.
- Timing:
  - Per-vector cost is SETTLE+1 cycles.
  - With start accepted at edge 0, done rises at edge 1+N*(SETTLE+1).
  - Example: mode 4, SETTLE=1 gives edge 129.
- Ignored inputs:
  - start while busy is ignored.
  - mode changes after acceptance are ignored.
  - start in the same cycle as rst: rst wins.
- Counters never wrap: the maximum reached is 64 < 2^CNT_W.

Test Plan:
- rst high for 2 cycles, then low, start with mode=4, dut_y driven by a correct mux_4x1 -> at reset all outputs are 0. Afterwards stim steps 0..63, done at edge 129 (SETTLE=1), vec_count=64, err_count=0, pass=1, fail_valid=0.
- mode=2, correct full adder/subtractor -> stim takes values 0..7 only, stim[5:3]=0 throughout, vec_count=8, pass=1.
- mode=1, dut_y[1] stuck at 0 -> err_count=1 (vector 3 only), fail_vec=6'd3, fail_valid=1, pass=0.
- mode=0, dut_y[1] toggling randomly, y correct -> err_count=0, pass=1 (mask check).
- mode=6 -> mode_err=1, done=1, pass=0, vec_count=0, busy never asserted. Then start mode=3 -> the run completes with vec_count=8 and mode_err cleared.
- Start mode=4, rst at edge 40, start pulses during busy in a separate run, SETTLE=3 build -> after rst all outputs are 0 and state is IDLE. Start pulses during busy do not restart or perturb the run. With SETTLE=3, mode 3 done arrives at edge 33.
